// File: rtl/pcie_tlp_defs.sv
// Shared TLP encodings, Tx credit indices and completion-header helpers
// for the BAR read completer.
package pcie_tlp_defs;

    localparam logic [1:0] FMT_3DW_ND = 2'b00;
    localparam logic [1:0] FMT_4DW_ND = 2'b01;
    localparam logic [1:0] FMT_3DW_D  = 2'b10;

    localparam logic [4:0] TYPE_MEM = 5'b00000;
    localparam logic [4:0] TYPE_CPL = 5'b01010;

    localparam logic [6:0] MRD32 = {FMT_3DW_ND, TYPE_MEM};
    localparam logic [6:0] MRD64 = {FMT_4DW_ND, TYPE_MEM};
    localparam logic [6:0] CPLD  = {FMT_3DW_D, TYPE_CPL};

    localparam logic [2:0] CPL_STATUS_SC = 3'b000;

    localparam int unsigned TBUF_NP_BIT  = 0;
    localparam int unsigned TBUF_P_BIT   = 1;
    localparam int unsigned TBUF_CPL_BIT = 2;

    typedef enum logic [2:0] {
        StIdle,
        StHdr2,
        StRdw,
        StReq,
        StTx1,
        StTx2
    } cpl_state_e;

    // Byte count of a 1-DW read, derived from the first-DW byte enables.
    function automatic logic [11:0] cpl_byte_count(input logic [3:0] be);
        logic [11:0] bc;
        casez (be)
            4'b1??1:                   bc = 12'd4;
            4'b01?1, 4'b1?10:          bc = 12'd3;
            4'b0011, 4'b0110, 4'b1100: bc = 12'd2;
            default:                   bc = 12'd1;
        endcase
        return bc;
    endfunction

    function automatic logic [6:0] cpl_lower_addr(input logic [4:0] addr_6_2,
                                                  input logic [3:0] be);
        logic [1:0] lo;
        casez (be)
            4'b???1: lo = 2'd0;
            4'b??10: lo = 2'd1;
            4'b?100: lo = 2'd2;
            4'b1000: lo = 2'd3;
            default: lo = 2'd0;
        endcase
        return {addr_6_2, lo};
    endfunction

endpackage

// File: rtl/cpl_hdr_gen.sv
// Combinational CplD builder: packs the four completion DWs into two
// 64-bit Tx beats from the fields captured off the MRd.
module cpl_hdr_gen
    import pcie_tlp_defs::*;
(
    input  logic [2:0]  tc_i,
    input  logic [1:0]  attr_i,
    input  logic [15:0] req_id_i,
    input  logic [7:0]  tag_i,
    input  logic [3:0]  first_be_i,
    input  logic [4:0]  addr_i,
    input  logic [15:0] completer_id_i,
    input  logic [31:0] data_i,
    output logic [63:0] beat1_o,
    output logic [63:0] beat2_o
);

    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] dw2;
    logic [31:0] dw3;

    always_comb begin
        dw0 = {1'b0, CPLD, 1'b0, tc_i, 4'b0000, 2'b00, attr_i, 2'b00, 10'd1};
        dw1 = {completer_id_i, CPL_STATUS_SC, 1'b0, cpl_byte_count(first_be_i)};
        dw2 = {req_id_i, tag_i, 1'b0, cpl_lower_addr(addr_i, first_be_i)};
        // Register data is little-endian; TLP payload is big-endian per DW.
        dw3 = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};
        beat1_o = {dw0, dw1};
        beat2_o = {dw2, dw3};
    end

endmodule

// File: rtl/bar_rd_completer.sv
// Answers 1-DW memory reads aimed at one BAR with a single CplD, sharing
// the Tx link with other masters through a req/gnt handshake.
module bar_rd_completer
    import pcie_tlp_defs::*;
#(
    parameter int unsigned BAR_INDEX = 0,
    parameter int unsigned REG_AW    = 8
) (
    input  logic              trn_clk,
    input  logic              trn_reset_n,
    input  logic              trn_lnk_up_n,
    input  logic [63:0]       trn_rd,
    input  logic [7:0]        trn_rrem_n,
    input  logic              trn_rsof_n,
    input  logic              trn_reof_n,
    input  logic              trn_rsrc_rdy_n,
    input  logic              trn_rsrc_dsc_n,
    input  logic [6:0]        trn_rbar_hit_n,
    output logic [63:0]       trn_td,
    output logic [7:0]        trn_trem_n,
    output logic              trn_tsof_n,
    output logic              trn_teof_n,
    output logic              trn_tsrc_rdy_n,
    input  logic              trn_tdst_rdy_n,
    input  logic [3:0]        trn_tbuf_av,
    input  logic [15:0]       cfg_completer_id,
    output logic              tx_req,
    input  logic              tx_gnt,
    output logic              reg_rd_en,
    output logic [REG_AW-1:0] reg_rd_addr,
    input  logic [31:0]       reg_rd_data,
    output logic              busy,
    output logic [15:0]       dropped_cnt
);

    cpl_state_e        state_q;
    logic              fmt64_q;
    logic [2:0]        tc_q;
    logic [1:0]        attr_q;
    logic [15:0]       req_id_q;
    logic [7:0]        tag_q;
    logic [3:0]        first_be_q;
    logic [4:0]        lower_q;
    logic [REG_AW-1:0] addr_q;
    logic [31:0]       data_q;

    logic              rst;
    logic              rx_beat;
    logic              mrd_hit;
    logic              addr_fire;
    logic [31:0]       addr_beat;
    logic [63:0]       hdr_beat1;
    logic [63:0]       hdr_beat2;
    logic              unused_in;

    // Link-down is treated exactly like reset.
    assign rst     = !trn_reset_n || trn_lnk_up_n;
    assign rx_beat = !trn_rsrc_rdy_n;

    assign mrd_hit = rx_beat && !trn_rsof_n &&
                     (trn_rd[62:56] == MRD32 || trn_rd[62:56] == MRD64) &&
                     (trn_rd[41:32] == 10'd1) && !trn_rbar_hit_n[BAR_INDEX];

    assign addr_beat = fmt64_q ? trn_rd[31:0] : trn_rd[63:32];
    assign addr_fire = !rst && (state_q == StHdr2) && rx_beat && trn_rsrc_dsc_n;

    // The register file sees the address in the same cycle as the Rx beat.
    assign reg_rd_en   = addr_fire;
    assign reg_rd_addr = addr_fire ? addr_beat[REG_AW+1:2] : addr_q;

    assign unused_in = ^{trn_rrem_n, trn_reof_n, trn_rd, trn_rbar_hit_n,
                         trn_tbuf_av, addr_beat};

    cpl_hdr_gen u_hdr (
        .tc_i           (tc_q),
        .attr_i         (attr_q),
        .req_id_i       (req_id_q),
        .tag_i          (tag_q),
        .first_be_i     (first_be_q),
        .addr_i         (lower_q),
        .completer_id_i (cfg_completer_id),
        .data_i         (data_q),
        .beat1_o        (hdr_beat1),
        .beat2_o        (hdr_beat2)
    );

    always_ff @(posedge trn_clk) begin
        if (rst) begin
            state_q        <= StIdle;
            fmt64_q        <= 1'b0;
            tc_q           <= 3'd0;
            attr_q         <= 2'd0;
            req_id_q       <= 16'd0;
            tag_q          <= 8'd0;
            first_be_q     <= 4'd0;
            lower_q        <= 5'd0;
            addr_q         <= '0;
            data_q         <= 32'd0;
            trn_td         <= 64'd0;
            trn_trem_n     <= 8'hFF;
            trn_tsof_n     <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
            tx_req         <= 1'b0;
            busy           <= 1'b0;
            dropped_cnt    <= 16'd0;
        end else begin
            if (mrd_hit && state_q != StIdle && dropped_cnt != 16'hFFFF) begin
                dropped_cnt <= dropped_cnt + 16'd1;
            end

            unique case (state_q)
                StIdle: begin
                    if (mrd_hit) begin
                        fmt64_q    <= trn_rd[61];
                        tc_q       <= trn_rd[54:52];
                        attr_q     <= trn_rd[45:44];
                        req_id_q   <= trn_rd[31:16];
                        tag_q      <= trn_rd[15:8];
                        first_be_q <= trn_rd[3:0];
                        busy       <= 1'b1;
                        state_q    <= StHdr2;
                    end
                end
                StHdr2: begin
                    if (!trn_rsrc_dsc_n) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (rx_beat) begin
                        addr_q  <= addr_beat[REG_AW+1:2];
                        lower_q <= addr_beat[6:2];
                        state_q <= StRdw;
                    end
                end
                StRdw: begin
                    data_q  <= reg_rd_data;
                    tx_req  <= 1'b1;
                    state_q <= StReq;
                end
                StReq: begin
                    if (tx_gnt && trn_tbuf_av[TBUF_CPL_BIT]) begin
                        trn_td         <= hdr_beat1;
                        trn_trem_n     <= 8'h00;
                        trn_tsof_n     <= 1'b0;
                        trn_tsrc_rdy_n <= 1'b0;
                        state_q        <= StTx1;
                    end
                end
                StTx1: begin
                    if (!trn_tdst_rdy_n) begin
                        trn_td     <= hdr_beat2;
                        trn_tsof_n <= 1'b1;
                        trn_teof_n <= 1'b0;
                        state_q    <= StTx2;
                    end
                end
                StTx2: begin
                    if (!trn_tdst_rdy_n) begin
                        trn_td         <= 64'd0;
                        trn_trem_n     <= 8'hFF;
                        trn_teof_n     <= 1'b1;
                        trn_tsrc_rdy_n <= 1'b1;
                        tx_req         <= 1'b0;
                        busy           <= 1'b0;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bar_rd_completer.sv
// Randomised scoreboard bench for bar_rd_completer: stimulus pushes expected
// reads and completions, negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_bar_rd_completer;

    localparam int unsigned BAR_INDEX = 2;
    localparam int unsigned REG_AW    = 8;

    logic              trn_clk = 1'b0;
    logic              trn_reset_n = 1'b0;
    logic              trn_lnk_up_n = 1'b0;
    logic [63:0]       trn_rd = 64'd0;
    logic [7:0]        trn_rrem_n = 8'hFF;
    logic              trn_rsof_n = 1'b1;
    logic              trn_reof_n = 1'b1;
    logic              trn_rsrc_rdy_n = 1'b1;
    logic              trn_rsrc_dsc_n = 1'b1;
    logic [6:0]        trn_rbar_hit_n = 7'h7F;
    logic [63:0]       trn_td;
    logic [7:0]        trn_trem_n;
    logic              trn_tsof_n;
    logic              trn_teof_n;
    logic              trn_tsrc_rdy_n;
    logic              trn_tdst_rdy_n = 1'b0;
    logic [3:0]        trn_tbuf_av = 4'hF;
    logic [15:0]       cfg_completer_id = 16'h0000;
    logic              tx_req;
    logic              tx_gnt = 1'b0;
    logic              reg_rd_en;
    logic [REG_AW-1:0] reg_rd_addr;
    logic [31:0]       reg_rd_data = 32'd0;
    logic              busy;
    logic [15:0]       dropped_cnt;

    always #5 trn_clk = ~trn_clk;

    bar_rd_completer #(.BAR_INDEX(BAR_INDEX), .REG_AW(REG_AW)) dut (
        .trn_clk(trn_clk), .trn_reset_n(trn_reset_n), .trn_lnk_up_n(trn_lnk_up_n),
        .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n), .trn_rsof_n(trn_rsof_n),
        .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
        .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rbar_hit_n(trn_rbar_hit_n),
        .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
        .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
        .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tbuf_av(trn_tbuf_av),
        .cfg_completer_id(cfg_completer_id), .tx_req(tx_req), .tx_gnt(tx_gnt),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .busy(busy), .dropped_cnt(dropped_cnt)
    );

    typedef struct packed {
        logic [63:0] b1;
        logic [63:0] b2;
    } cpl_t;

    cpl_t              exp_q[$];
    logic [REG_AW-1:0] exp_addr_q[$];
    logic [31:0]       regs [2**REG_AW];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_dropped = 0;
    int eof_cyc = 0;
    int sof_cyc = 0;
    int tx_done = 0;
    bit model_busy = 1'b0;
    bit gnt_allow = 1'b1;
    bit gnt_rand = 1'b0;
    bit tbuf_rand = 1'b0;
    int rdy_mode = 0;  // 0 ready, 1 random, 2 never, 3 alternate

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not allowed here", name);
    endtask

    // Reference: byte count is the span from lowest to highest enabled byte.
    function automatic logic [11:0] ref_bc(input logic [3:0] be);
        int lo = -1;
        int hi = -1;
        for (int i = 0; i < 4; i++) if (be[i]) begin
            if (lo < 0) lo = i;
            hi = i;
        end
        return (lo < 0) ? 12'd1 : 12'(hi - lo + 1);
    endfunction

    function automatic logic [1:0] ref_lo(input logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic cpl_t ref_cpl(input logic [31:0] addr, input logic [3:0] be,
                                     input logic [7:0] tag, input logic [15:0] rid,
                                     input logic [2:0] tc, input logic [1:0] attr);
        cpl_t c;
        logic [31:0] d;
        logic [31:0] sw;
        d = regs[addr[REG_AW+1:2]];
        for (int i = 0; i < 4; i++) sw[8*(3-i) +: 8] = d[8*i +: 8];
        c.b1[63:32] = 32'h4A000001 | (32'(tc) << 20) | (32'(attr) << 12);
        c.b1[31:0]  = (32'(cfg_completer_id) << 16) | 32'(ref_bc(be));
        c.b2[63:32] = (32'(rid) << 16) | (32'(tag) << 8) | (32'(addr[6:2]) << 2)
                      | 32'(ref_lo(be));
        c.b2[31:0]  = sw;
        return c;
    endfunction

    always @(posedge trn_clk) cyc <= cyc + 1;

    always @(posedge trn_clk) if (reg_rd_en) reg_rd_data <= regs[reg_rd_addr];

    // Tx arbiter and sink models.
    always @(posedge trn_clk) begin
        #1;
        if (!tx_req) tx_gnt = 1'b0;
        else if (!tx_gnt && gnt_allow && (!gnt_rand || $urandom_range(0, 2) == 0))
            tx_gnt = 1'b1;
        case (rdy_mode)
            1: trn_tdst_rdy_n = ($urandom_range(0, 2) == 0);
            2: trn_tdst_rdy_n = 1'b1;
            3: trn_tdst_rdy_n = ~trn_tdst_rdy_n;
            default: trn_tdst_rdy_n = 1'b0;
        endcase
        trn_tbuf_av = (tbuf_rand && $urandom_range(0, 3) == 0) ? 4'b1011 : 4'hF;
    end

    // Monitor: register reads, Tx beats, beat holding and tx_req release.
    logic [63:0] held_td;
    logic [63:0] b1_got;
    bit held = 1'b0;
    bit beat1_seen = 1'b0;
    bit chk_req_drop = 1'b0;

    always @(negedge trn_clk) begin
        if (!trn_reset_n || trn_lnk_up_n) begin
            held = 1'b0;
            beat1_seen = 1'b0;
            chk_req_drop = 1'b0;
        end else begin
            if (chk_req_drop) begin
                chk("tx_req_release", 64'(tx_req), 64'd0);
                chk_req_drop = 1'b0;
            end
            if (reg_rd_en) begin
                if (exp_addr_q.size() == 0) bad("reg_rd_en_unexpected");
                else chk("reg_rd_addr", 64'(reg_rd_addr), 64'(exp_addr_q.pop_front()));
            end
            if (held) chk("beat_hold", trn_td, held_td);
            if (!trn_tsrc_rdy_n) begin
                if (!trn_tsof_n && !held) sof_cyc = cyc;
                if (!trn_tdst_rdy_n) begin
                    if (!trn_tsof_n) begin
                        if (beat1_seen) bad("double_sof");
                        b1_got = trn_td;
                        beat1_seen = 1'b1;
                    end else if (!trn_teof_n) begin
                        chk("trem_n", 64'(trn_trem_n), 64'h00);
                        if (!beat1_seen) bad("eof_without_sof");
                        else if (exp_q.size() == 0) bad("cpl_unexpected");
                        else begin
                            cpl_t e;
                            e = exp_q.pop_front();
                            chk("cpl_beat1", b1_got, e.b1);
                            chk("cpl_beat2", trn_td, e.b2);
                        end
                        beat1_seen = 1'b0;
                        model_busy = 1'b0;
                        chk_req_drop = 1'b1;
                        tx_done++;
                    end
                end
                held = trn_tdst_rdy_n;
                held_td = trn_td;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic send_tlp(input logic [1:0] fmt, input logic [9:0] len, input bit hit,
                            input logic [31:0] addr, input logic [3:0] be,
                            input logic [7:0] tag, input logic [15:0] rid,
                            input logic [2:0] tc, input logic [1:0] attr,
                            input int gap, input bit dsc);
        logic [31:0] dw0;
        logic [6:0]  bar;
        bit          pat;
        pat = (fmt == 2'b00 || fmt == 2'b01) && len == 10'd1 && hit;
        if (pat) begin
            if (model_busy) begin
                if (exp_dropped < 65535) exp_dropped++;
            end else if (!dsc) begin
                model_busy = 1'b1;
                exp_addr_q.push_back(addr[REG_AW+1:2]);
                exp_q.push_back(ref_cpl(addr, be, tag, rid, tc, attr));
            end
        end
        dw0 = {1'b0, fmt, 5'b00000, 1'b0, tc, 4'b0000, 2'b00, attr, 2'b00, len};
        bar = hit ? ~(7'b1 << BAR_INDEX) : ~(7'b1 << ((BAR_INDEX + 1 + $urandom_range(0, 5)) % 7));
        @(posedge trn_clk); #1;
        trn_rd = {dw0, rid, tag, 4'h0, be};
        trn_rsof_n = 1'b0;
        trn_reof_n = 1'b1;
        trn_rrem_n = 8'h00;
        trn_rsrc_rdy_n = 1'b0;
        trn_rbar_hit_n = bar;
        for (int g = 0; g < gap; g++) begin
            @(posedge trn_clk); #1;
            trn_rsrc_rdy_n = 1'b1;
            trn_rsof_n = 1'b1;
        end
        @(posedge trn_clk); #1;
        trn_rsof_n = 1'b1;
        if (dsc) begin
            trn_rsrc_rdy_n = 1'b1;
            trn_rsrc_dsc_n = 1'b0;
            @(posedge trn_clk); #1;
            trn_rsrc_dsc_n = 1'b1;
        end else begin
            trn_rd = fmt[0] ? {32'h0, addr} : {addr, 32'h0};
            trn_rrem_n = fmt[0] ? 8'h00 : 8'h0F;
            trn_reof_n = 1'b0;
            trn_rsrc_rdy_n = 1'b0;
            eof_cyc = cyc;
            @(posedge trn_clk); #1;
            trn_rsrc_rdy_n = 1'b1;
            trn_reof_n = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((busy || model_busy) && k < budget) begin
            @(posedge trn_clk); #1;
            k++;
        end
        if (k >= budget) bad({name, "_timeout"});
    endtask

    task automatic flush_model();
        exp_q.delete();
        exp_addr_q.delete();
        model_busy = 1'b0;
        exp_dropped = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int drops_before;
        int done_before;
        for (int i = 0; i < 2**REG_AW; i++) regs[i] = $urandom;
        regs[4] = 32'h11223344;
        cfg_completer_id = 16'($urandom);

        // Reset values.
        repeat (3) @(posedge trn_clk);
        @(negedge trn_clk);
        chk("rst_tsrc_rdy_n", 64'(trn_tsrc_rdy_n), 64'd1);
        chk("rst_tsof_teof", 64'({trn_tsof_n, trn_teof_n}), 64'h3);
        chk("rst_td", trn_td, 64'd0);
        chk("rst_trem_n", 64'(trn_trem_n), 64'hFF);
        chk("rst_ctrl", 64'({tx_req, reg_rd_en, busy}), 64'd0);
        chk("rst_rd_addr", 64'(reg_rd_addr), 64'd0);
        chk("rst_dropped", 64'(dropped_cnt), 64'd0);
        @(posedge trn_clk); #1;
        trn_reset_n = 1'b1;
        repeat (2) @(posedge trn_clk);

        // 1: MRd32 with immediate grant, minimum latency.
        send_tlp(2'b00, 10'd1, 1'b1, 32'h10, 4'hF, 8'h05, 16'h0100, 3'd0, 2'd0, 0, 1'b0);
        wait_idle("t1", 40);
        chk("t1_latency", 64'(sof_cyc - eof_cyc), 64'd3);

        // 2: MRd64 with partial byte enable.
        send_tlp(2'b01, 10'd1, 1'b1, 32'h24, 4'b0100, 8'h3C, 16'hBEEF, 3'd5, 2'd2, 1, 1'b0);
        wait_idle("t2", 40);

        // 3: wrong length and BAR miss are ignored.
        drops_before = exp_dropped;
        send_tlp(2'b00, 10'd2, 1'b1, 32'h40, 4'hF, 8'h01, 16'h0001, 3'd0, 2'd0, 0, 1'b0);
        send_tlp(2'b00, 10'd1, 1'b0, 32'h44, 4'hF, 8'h02, 16'h0001, 3'd0, 2'd0, 0, 1'b0);
        repeat (6) @(posedge trn_clk); #1;
        chk("t3_idle", 64'({tx_req, busy}), 64'd0);
        chk("t3_dropped", 64'(dropped_cnt), 64'(drops_before));

        // 4: late grant, then destination stalls on both beats.
        gnt_allow = 1'b0;
        done_before = tx_done;
        send_tlp(2'b00, 10'd1, 1'b1, 32'h80, 4'b0011, 8'h77, 16'h1234, 3'd1, 2'd1, 0, 1'b0);
        k = 0;
        while (!tx_req && k < 20) begin @(posedge trn_clk); #1; k++; end
        if (k >= 20) bad("t4_req_timeout");
        repeat (10) @(posedge trn_clk); #1;
        chk("t4_no_tx_without_gnt", 64'(trn_tsrc_rdy_n), 64'd1);
        rdy_mode = 3;
        gnt_allow = 1'b1;
        wait_idle("t4", 60);
        chk("t4_one_cpl", 64'(tx_done - done_before), 64'd1);
        rdy_mode = 0;

        // 5: second MRd while waiting for the link is dropped.
        gnt_allow = 1'b0;
        done_before = tx_done;
        send_tlp(2'b00, 10'd1, 1'b1, 32'hC8, 4'b1000, 8'h11, 16'h00AA, 3'd0, 2'd0, 0, 1'b0);
        k = 0;
        while (!tx_req && k < 20) begin @(posedge trn_clk); #1; k++; end
        if (k >= 20) bad("t5_req_timeout");
        send_tlp(2'b01, 10'd1, 1'b1, 32'h30, 4'hF, 8'h12, 16'h00AB, 3'd0, 2'd0, 0, 1'b0);
        chk("t5_dropped", 64'(dropped_cnt), 64'(exp_dropped));
        gnt_allow = 1'b1;
        wait_idle("t5", 40);
        repeat (8) @(posedge trn_clk); #1;
        chk("t5_one_cpl", 64'(tx_done - done_before), 64'd1);

        // 6: reset while beat 1 is stalled, then a normal read.
        rdy_mode = 2;
        send_tlp(2'b00, 10'd1, 1'b1, 32'h14, 4'hF, 8'h21, 16'h0300, 3'd0, 2'd0, 0, 1'b0);
        k = 0;
        while (trn_tsof_n && k < 30) begin @(posedge trn_clk); #1; k++; end
        if (k >= 30) bad("t6_tx1_timeout");
        trn_reset_n = 1'b0;
        flush_model();
        @(posedge trn_clk); #1;
        trn_reset_n = 1'b1;
        rdy_mode = 0;
        @(negedge trn_clk);
        chk("t6_tsrc_rdy_n", 64'(trn_tsrc_rdy_n), 64'd1);
        chk("t6_req_busy", 64'({tx_req, busy}), 64'd0);
        chk("t6_dropped", 64'(dropped_cnt), 64'd0);
        send_tlp(2'b00, 10'd1, 1'b1, 32'h18, 4'b0110, 8'h22, 16'h0301, 3'd2, 2'd3, 0, 1'b0);
        wait_idle("t6", 40);

        // 7: discontinue before the address beat.
        send_tlp(2'b00, 10'd1, 1'b1, 32'h1C, 4'hF, 8'h23, 16'h0302, 3'd0, 2'd0, 0, 1'b1);
        repeat (4) @(posedge trn_clk); #1;
        chk("t7_dsc_idle", 64'({tx_req, busy}), 64'd0);

        // Randomised traffic with back-pressure, credit gaps and overlap.
        rdy_mode = 1;
        gnt_rand = 1'b1;
        tbuf_rand = 1'b1;
        for (int t = 0; t < 80; t++) begin
            int kind;
            logic [1:0] fmt;
            logic [9:0] len;
            bit hit;
            kind = $urandom_range(0, 9);
            fmt = 2'($urandom_range(0, 1));
            len = 10'd1;
            hit = 1'b1;
            if (kind == 0) len = 10'($urandom_range(2, 8));
            if (kind == 1) hit = 1'b0;
            if (kind == 2) fmt = 2'b10;
            send_tlp(fmt, len, hit, {20'($urandom), 10'($urandom), 2'b00}, 4'($urandom),
                     8'($urandom), 16'($urandom), 3'($urandom), 2'($urandom),
                     $urandom_range(0, 2), 1'b0);
            if ($urandom_range(0, 3) != 0) wait_idle("rand", 200);
        end
        wait_idle("rand_end", 200);
        repeat (4) @(posedge trn_clk); #1;
        chk("final_dropped", 64'(dropped_cnt), 64'(exp_dropped));
        chk("final_cpl_left", 64'(exp_q.size()), 64'd0);
        chk("final_rd_left", 64'(exp_addr_q.size()), 64'd0);

        // Link down clears the drop counter.
        trn_lnk_up_n = 1'b1;
        flush_model();
        @(posedge trn_clk); #1;
        trn_lnk_up_n = 1'b0;
        @(negedge trn_clk);
        chk("lnk_down_dropped", 64'(dropped_cnt), 64'd0);
        chk("lnk_down_strobes", 64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}), 64'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
